// File: rtl/mips32_pkg.sv
// Shared opcodes, instruction classes and scoreboard types for the MIPS32 pipeline control.
package mips32_pkg;

    localparam logic [5:0] ADD   = 6'h00;
    localparam logic [5:0] SUB   = 6'h01;
    localparam logic [5:0] AND   = 6'h02;
    localparam logic [5:0] OR    = 6'h03;
    localparam logic [5:0] SLT   = 6'h04;
    localparam logic [5:0] MUL   = 6'h05;
    localparam logic [5:0] ADDI  = 6'h09;
    localparam logic [5:0] SUBI  = 6'h0A;
    localparam logic [5:0] SLTI  = 6'h0B;
    localparam logic [5:0] BNEQZ = 6'h0D;
    localparam logic [5:0] BEQZ  = 6'h0E;
    localparam logic [5:0] LW    = 6'h11;
    localparam logic [5:0] SW    = 6'h12;
    localparam logic [5:0] HLT   = 6'h3F;

    typedef enum logic [2:0] {
        RR_ALU,
        RM_ALU,
        LOAD,
        STORE,
        BRANCH,
        HALT,
        OTHER
    } instr_type_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
    } sb_entry_t;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StDrain,
        StHalted
    } hz_state_e;

    function automatic instr_type_e op_type(input logic [5:0] op);
        instr_type_e t;
        case (op)
            ADD, SUB, AND, OR, SLT, MUL: t = RR_ALU;
            ADDI, SUBI, SLTI:            t = RM_ALU;
            LW:                          t = LOAD;
            SW:                          t = STORE;
            BNEQZ, BEQZ:                 t = BRANCH;
            HLT:                         t = HALT;
            default:                     t = OTHER;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mips32_reg_decode.sv
// Register-usage decode of an IF/ID instruction; R0 is masked out of every use-bit.
module mips32_reg_decode
    import mips32_pkg::*;
(
    input  logic [31:0] ir_i,
    output instr_type_e itype_o,
    output logic [4:0]  src1_o,
    output logic        src1_use_o,
    output logic [4:0]  src2_o,
    output logic        src2_use_o,
    output logic [4:0]  dest_o,
    output logic        dest_use_o
);

    logic [4:0]  rs, rt, rd;
    logic        s1_use, s2_use, d_use;
    logic [4:0]  dest;
    instr_type_e itype;

    assign rs = ir_i[25:21];
    assign rt = ir_i[20:16];
    assign rd = ir_i[15:11];

    always_comb begin
        itype  = op_type(ir_i[31:26]);
        s1_use = 1'b0;
        s2_use = 1'b0;
        d_use  = 1'b0;
        dest   = 5'd0;
        case (itype)
            RR_ALU: begin
                s1_use = 1'b1;
                s2_use = 1'b1;
                d_use  = 1'b1;
                dest   = rd;
            end
            RM_ALU, LOAD: begin
                s1_use = 1'b1;
                d_use  = 1'b1;
                dest   = rt;
            end
            STORE: begin
                s1_use = 1'b1;
                s2_use = 1'b1;
            end
            BRANCH: s1_use = 1'b1;
            default: ;
        endcase
    end

    // R0 is hardwired: it can neither create nor consume a dependency.
    assign itype_o    = itype;
    assign src1_o     = rs;
    assign src2_o     = rt;
    assign dest_o     = dest;
    assign src1_use_o = s1_use && (rs != 5'd0);
    assign src2_use_o = s2_use && (rt != 5'd0);
    assign dest_use_o = d_use && (dest != 5'd0);

endmodule

// File: rtl/mips32_hazard_ctrl.sv
// RAW interlock, taken-branch flush and HLT drain sequencing for the 5-stage MIPS32 pipeline.
module mips32_hazard_ctrl
    import mips32_pkg::*;
#(
    parameter int unsigned BRANCH_PENALTY = 2,
    parameter int unsigned WB_BYPASS      = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [31:0]      id_ir,
    input  logic             br_taken,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned FC_W = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;

    instr_type_e itype;
    logic [4:0]  src1, src2, dest;
    logic        src1_use, src2_use, dest_use;

    mips32_reg_decode u_decode (
        .ir_i       (id_ir),
        .itype_o    (itype),
        .src1_o     (src1),
        .src1_use_o (src1_use),
        .src2_o     (src2),
        .src2_use_o (src2_use),
        .dest_o     (dest),
        .dest_use_o (dest_use)
    );

    hz_state_e        state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    sb_entry_t        sb_ex_q, sb_mem_q, sb_wb_q;
    sb_entry_t        sb_ex_d, sb_mem_d, sb_wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic raw, sb_empty, issue, stall_inc, flush_inc;

    function automatic logic hit(input logic use_r, input logic [4:0] r, input sb_entry_t e);
        return use_r && e.valid && (e.dest == r);
    endfunction

    always_comb begin
        raw = hit(src1_use, src1, sb_ex_q)  || hit(src2_use, src2, sb_ex_q) ||
              hit(src1_use, src1, sb_mem_q) || hit(src2_use, src2, sb_mem_q);
        if (WB_BYPASS == 0) begin
            raw = raw || hit(src1_use, src1, sb_wb_q) || hit(src2_use, src2, sb_wb_q);
        end
        raw = raw && id_valid;
    end

    assign sb_empty = !sb_ex_q.valid && !sb_mem_q.valid && !sb_wb_q.valid;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            StRun: begin
                if (br_taken) begin
                    state_d = StFlush;
                    fcnt_d  = FC_W'(BRANCH_PENALTY - 1);
                end else if (id_valid && !raw && (itype == HALT)) begin
                    state_d = StDrain;
                end
            end
            StFlush: begin
                if (fcnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            // A branch older than the HLT can still resolve taken; the HLT is then its shadow.
            StDrain: begin
                if (br_taken) begin
                    state_d = StFlush;
                    fcnt_d  = FC_W'(BRANCH_PENALTY - 1);
                end else if (sb_empty) begin
                    state_d = StHalted;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        stall_if    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        halted      = 1'b0;
        issue       = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        case (state_q)
            StRun: begin
                if (!br_taken) begin
                    stall_if  = raw;
                    bubble_ex = raw;
                    stall_inc = raw;
                    issue     = id_valid && !raw;
                end
            end
            StFlush: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                flush_inc   = 1'b1;
            end
            StDrain: begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
            end
            StHalted: begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
                halted    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        sb_ex_d  = '0;
        sb_mem_d = sb_ex_q;
        sb_wb_d  = sb_mem_q;
        if (issue && dest_use) begin
            sb_ex_d = '{valid: 1'b1, dest: dest};
        end
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            sb_ex_q     <= '0;
            sb_mem_q    <= '0;
            sb_wb_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_ex_q     <= sb_ex_d;
            sb_mem_q    <= sb_mem_d;
            sb_wb_q     <= sb_wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
